led_target_gen: RTL
===================

LED_TARGET_GEN -- requirements
Module: led_target_gen

Interface
REQ-001 Parameter NUM_LEDS, default 8, meaning number of LED targets, legal range 2..16.
REQ-002 Parameter RND_W, default 13, meaning width of random input, must be >= clog2(NUM_LEDS).
REQ-003 Parameter ON_CYCLES, default 100000000, meaning clk cycles a target stays lit, must be >= 1.
REQ-004 Parameter NO_REPEAT, default 1, meaning 1 forbids the same index on consecutive picks.
REQ-005 Parameter CNT_W, default 16, meaning width of hit/miss counters.
REQ-006 clk  in  1  single system clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 en  in  1  level enable; low forces idle.
REQ-009 freq  in  1  single-cycle pulse requesting a new target.
REQ-010 rnd  in  RND_W  random value from lfsr, sampled only on accepted freq.
REQ-011 btn  in  NUM_LEDS  single-cycle press pulses, debounced upstream.
REQ-012 clear  in  1  synchronous clear of hit/miss counters.
REQ-013 led_onehot  out  NUM_LEDS  one-hot lit LED, all zero when idle.
REQ-014 led_idx  out  clog2(NUM_LEDS)  index of current/last target.
REQ-015 lit  out  1  high while a target is lit.
REQ-016 hit_cnt  out  CNT_W  saturating count of correct presses.
REQ-017 miss_cnt  out  CNT_W  saturating count of timeouts, wrong presses, preemptions.

Function
REQ-018 FSM states IDLE and LIT; all outputs registered.
REQ-019 Pick: raw = rnd[IDX_W-1:0]; if raw >= NUM_LEDS then raw - NUM_LEDS (single subtract, IDX_W = clog2(NUM_LEDS)).
REQ-020 NO_REPEAT=1: if pick equals current led_idx, use led_idx+1, wrapping NUM_LEDS-1 -> 0; NO_REPEAT=0: pick used unchanged.
REQ-021 freq with en=1 in cycle T: led_idx, led_onehot, lit valid at T+1 (latency 1), on-timer loaded with ON_CYCLES-1.
REQ-022 LIT: on-timer decrements each cycle; at 0 with no event -> IDLE, led_onehot=0, miss_cnt+1.
REQ-023 LIT, btn[led_idx]=1 -> IDLE next cycle, hit_cnt+1; other btn bits ignored that cycle.
REQ-024 LIT, btn nonzero and btn[led_idx]=0 -> miss_cnt+1, stay LIT, timer continues.
REQ-025 IDLE: btn ignored, counters unchanged.
REQ-026 freq in LIT without correct press: previous target counted as miss, new target picked, timer reloaded.
REQ-027 freq and correct press same cycle in LIT: hit_cnt+1, new target picked, no miss counted.
REQ-028 freq and timer expiry same cycle: miss_cnt+1 once, new target picked, stay LIT.
REQ-029 en=0: IDLE next cycle, led_onehot=0, counters hold, freq/btn ignored; led_idx holds.
REQ-030 Counters saturate at 2^CNT_W-1; clear zeroes both and takes priority over same-cycle increments.

Reset
REQ-031 rst_n low: state IDLE, led_onehot=0, led_idx=0, lit=0, hit_cnt=0, miss_cnt=0, timer=0, immediately and asynchronously.
REQ-032 Reset mid-LIT discards the target; first freq after release is handled normally.

Structure
REQ-033 Shared package holds FSM state enum and default constants (NUM_LEDS, ON_CYCLES, CNT_W).
REQ-034 One sub-module, sat_counter (CNT_W, inc, clr), instantiated for hit_cnt and miss_cnt.
REQ-035 Implementation 120-400 RTL lines; no division or modulo operator.

Verification (ON_CYCLES=10, NUM_LEDS=6, NO_REPEAT=1)
REQ-036 Reset, freq with rnd=13'h0003 -> next cycle led_idx=3, led_onehot=6'b001000, lit=1; 10 cycles later lit=0, miss_cnt=1.
REQ-037 rnd=13'h0007 -> raw 7 folds to idx 1; then freq with rnd=13'h0001 -> idx 2 (no-repeat bump); with NO_REPEAT=0 -> idx 1.
REQ-038 Lit idx 5, rnd=13'h0005 again -> idx wraps to 0.
REQ-039 Lit idx 2: btn=6'b000001 -> miss_cnt+1, still lit; btn=6'b000100 -> hit_cnt=1, led_onehot=0.
REQ-040 freq and correct btn same cycle -> hit_cnt+1, new target, miss_cnt unchanged; freq on expiry cycle -> miss_cnt+1 once.
REQ-041 CNT_W=2, four hits -> hit_cnt=3 saturated; clear with hit same cycle -> 0; rst_n low mid-LIT -> all outputs 0 without clk edge.

Source files
------------

// File: rtl/led_target_gen_pkg.sv
// Shared types and default constants for the LED target generator.
package led_target_gen_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LIT  = 1'b1
   } state_e;

   localparam int DEF_NUM_LEDS  = 8;
   localparam int DEF_RND_W     = 13;
   localparam int DEF_ON_CYCLES = 100000000;
   localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/led_target_gen_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increments.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/led_target_gen.sv
// Whack-a-mole style target generator: lights one random LED per freq pulse and
// scores presses against it with saturating hit/miss counters.
module led_target_gen
   import led_target_gen_pkg::*;
#(
   parameter int NUM_LEDS  = DEF_NUM_LEDS,
   parameter int RND_W     = DEF_RND_W,
   parameter int ON_CYCLES = DEF_ON_CYCLES,
   parameter int NO_REPEAT = 1,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        freq,
   input  logic [RND_W-1:0]            rnd,
   input  logic [NUM_LEDS-1:0]         btn,
   input  logic                        clear,
   output logic [NUM_LEDS-1:0]         led_onehot,
   output logic [$clog2(NUM_LEDS)-1:0] led_idx,
   output logic                        lit,
   output logic [CNT_W-1:0]            hit_cnt,
   output logic [CNT_W-1:0]            miss_cnt
);

   localparam int IDX_W = $clog2(NUM_LEDS);
   localparam int TMR_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ON_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);

   state_e              state_q, state_d;
   logic [NUM_LEDS-1:0] led_onehot_q, led_onehot_d;
   logic [IDX_W-1:0]    led_idx_q, led_idx_d;
   logic                lit_q, lit_d;
   logic [TMR_W-1:0]    timer_q, timer_d;

   logic [IDX_W:0]      raw_ext;
   logic [IDX_W-1:0]    pick_fold;
   logic [IDX_W-1:0]    pick;
   logic                press_ok;
   logic                press_any;
   logic                expired;
   logic                hit_inc;
   logic                miss_inc;
   logic                unused_rnd;

   // Only the low IDX_W bits of rnd feed the pick.
   assign unused_rnd = ^rnd;

   function automatic logic [NUM_LEDS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_LEDS-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         oh[i] = (idx == IDX_W'(i));
      end
      return oh;
   endfunction

   // Fold out-of-range raw values with one subtract, then bump on a repeat.
   always_comb begin
      raw_ext = {1'b0, rnd[IDX_W-1:0]};
      if (raw_ext >= (IDX_W+1)'(NUM_LEDS)) begin
         raw_ext = raw_ext - (IDX_W+1)'(NUM_LEDS);
      end
      pick_fold = raw_ext[IDX_W-1:0];
      pick      = pick_fold;
      if ((NO_REPEAT != 0) && (pick_fold == led_idx_q)) begin
         pick = (led_idx_q == IDX_LAST) ? '0 : led_idx_q + IDX_W'(1);
      end
   end

   always_comb begin
      press_any    = |btn;
      press_ok     = |(btn & led_onehot_q);
      expired      = (timer_q == '0);
      state_d      = state_q;
      led_onehot_d = led_onehot_q;
      led_idx_d    = led_idx_q;
      lit_d        = lit_q;
      timer_d      = timer_q;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      if (!en) begin
         state_d      = ST_IDLE;
         led_onehot_d = '0;
         lit_d        = 1'b0;
         timer_d      = '0;
      end else if (freq) begin
         // A pending target is scored before being replaced; expiry and preemption count once.
         if (state_q == ST_LIT) begin
            if (press_ok) begin
               hit_inc = 1'b1;
            end else begin
               miss_inc = 1'b1;
            end
         end
         state_d      = ST_LIT;
         led_idx_d    = pick;
         led_onehot_d = idx_to_onehot(pick);
         lit_d        = 1'b1;
         timer_d      = TMR_LOAD;
      end else if (state_q == ST_LIT) begin
         if (press_ok) begin
            hit_inc      = 1'b1;
            state_d      = ST_IDLE;
            led_onehot_d = '0;
            lit_d        = 1'b0;
            timer_d      = '0;
         end else begin
            miss_inc = press_any || expired;
            if (expired) begin
               state_d      = ST_IDLE;
               led_onehot_d = '0;
               lit_d        = 1'b0;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         led_onehot_q <= '0;
         led_idx_q    <= '0;
         lit_q        <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         led_onehot_q <= led_onehot_d;
         led_idx_q    <= led_idx_d;
         lit_q        <= lit_d;
         timer_q      <= timer_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit_inc),
      .clr   (clear),
      .cnt   (hit_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (miss_inc),
      .clr   (clear),
      .cnt   (miss_cnt)
   );

   assign led_onehot = led_onehot_q;
   assign led_idx    = led_idx_q;
   assign lit        = lit_q;

endmodule
